// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate stage: one dot-product per vector, delimited
// by in_last, with a sticky signed-overflow flag per vector.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b/in_last
// operand stream; out_valid/out_ready/out_data/out_count/out_ovf result.
module mac_accumulator #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   typedef enum logic [1:0] {
      ACCUM,
      DRAIN,
      OUT
   } state_t;

   state_t r_state;
   state_t w_next;

   logic                     w_beat;
   logic signed [DATA_W-1:0] w_a;
   logic signed [DATA_W-1:0] w_b;
   logic signed [ACC_W-1:0]  w_prod;

   logic                     r_p_valid;
   logic                     r_p_last;
   logic [ACC_W-1:0]         r_prod;

   logic [ACC_W-1:0]         r_acc;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_ovf;
   logic [ACC_W-1:0]         w_sum;
   logic                     w_ovf_now;

   logic [ACC_W-1:0]         r_out_data;
   logic [CNT_W-1:0]         r_out_count;
   logic                     r_out_ovf;

   assign in_ready = (r_state == ACCUM) && !rst;
   assign w_beat   = in_valid && in_ready;

   // Both operands are widened before multiplying; since ACC_W >= 2*DATA_W
   // the truncated product equals the sign-extended full product.
   assign w_a    = in_a;
   assign w_b    = in_b;
   assign w_prod = ACC_W'(w_a) * ACC_W'(w_b);

   // Stage P: registered product
   always_ff @(posedge clk) begin
      if (rst) begin
         r_p_valid <= 1'b0;
         r_p_last  <= 1'b0;
         r_prod    <= '0;
      end else begin
         r_p_valid <= w_beat;
         if (w_beat) begin
            r_p_last <= in_last;
            r_prod   <= w_prod;
         end
      end
   end

   // Stage A: modular add; overflow when like-signed operands give a
   // result of the opposite sign.
   assign w_sum     = r_acc + r_prod;
   assign w_ovf_now = (r_acc[ACC_W-1] == r_prod[ACC_W-1]) &&
                      (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_out_data  <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
      end else if (r_p_valid) begin
         if (!r_p_last) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= r_ovf | w_ovf_now;
         end else begin
            r_out_data  <= w_sum;
            r_out_count <= r_cnt + CNT_W'(1);
            r_out_ovf   <= r_ovf | w_ovf_now;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next state
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ACCUM: begin
            if (w_beat && in_last) begin
               w_next = DRAIN;
            end
         end
         DRAIN: begin
            if (r_p_valid && r_p_last) begin
               w_next = OUT;
            end
         end
         OUT: begin
            if (out_ready) begin
               w_next = ACCUM;
            end
         end
         default: w_next = ACCUM;
      endcase
   end

   // Result registers only change in stage A, which is idle while in OUT,
   // so they stay stable until the handshake.
   assign out_valid = (r_state == OUT);
   assign out_data  = r_out_data;
   assign out_count = r_out_count;
   assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: directed vectors push expected
// results; a monitor pops and compares on each output handshake.
module tb_mac_accumulator;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [15:0] out_count;
   logic        out_ovf;

   typedef struct {
      logic [31:0] d;
      logic [15:0] c;
      logic        o;
   } exp_t;

   exp_t sb[$];
   int   n_cmp;
   int   n_bad;

   mac_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_count (out_count),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got %h want none", out_data);
         end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_count", 32'(out_count), 32'(e.c));
            chk("out_ovf", 32'(out_ovf), 32'(e.o));
         end
      end
   end

   task automatic push(input logic [31:0] d, input logic [15:0] c,
                       input logic o);
      exp_t e;
      e.d = d;
      e.c = c;
      e.o = o;
      sb.push_back(e);
   endtask

   // Returns at posedge+1 of the edge that transferred the beat.
   task automatic beat(input logic [15:0] a, input logic [15:0] b,
                       input logic last);
      int k;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!in_ready && k < 50);
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL beat_timeout: got in_ready=0 want 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Basic vector plus exact output timing
      push(32'h0000_0023, 16'd3, 1'b0);
      beat(16'd2, 16'd3, 1'b0);
      beat(16'hFFFC, 16'd5, 1'b0);
      beat(16'd7, 16'd7, 1'b1);
      @(negedge clk);
      chk("t1_valid_n1", 32'(out_valid), 32'd0);
      chk("t1_ready_n1", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("t1_valid_n2", 32'(out_valid), 32'd1);
      chk("t1_ready_n2", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("t1_valid_n3", 32'(out_valid), 32'd0);
      chk("t1_ready_n3", 32'(in_ready), 32'd1);
      drain();

      // Single beat, most negative squared
      push(32'h4000_0000, 16'd1, 1'b0);
      beat(16'h8000, 16'h8000, 1'b1);
      drain();

      // Overflow then sticky clear
      push(32'hBFFD_0003, 16'd3, 1'b1);
      push(32'h0000_0001, 16'd1, 1'b0);
      beat(16'h7FFF, 16'h7FFF, 1'b0);
      beat(16'h7FFF, 16'h7FFF, 1'b0);
      beat(16'h7FFF, 16'h7FFF, 1'b1);
      beat(16'd1, 16'd1, 1'b1);
      drain();

      // Backpressure
      out_ready = 1'b0;
      push(32'd13, 16'd2, 1'b0);
      push(32'd30, 16'd1, 1'b0);
      beat(16'd2, 16'd2, 1'b0);
      beat(16'd3, 16'd3, 1'b1);
      in_valid = 1'b1;
      in_a     = 16'd5;
      in_b     = 16'd6;
      in_last  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_data", out_data, 32'd13);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      chk("bp_hs_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("bp_after_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      drain();

      // Bubbles
      push(32'd14, 16'd2, 1'b0);
      beat(16'd1, 16'd2, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      beat(16'd3, 16'd4, 1'b1);
      drain();

      // Reset mid-vector discards the partial sum
      beat(16'd10, 16'd10, 1'b0);
      beat(16'd20, 16'd20, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data", out_data, 32'd0);
      chk("mid_rst_out_count", 32'(out_count), 32'd0);
      chk("mid_rst_out_ovf", 32'(out_ovf), 32'd0);
      rst = 1'b0;
      push(32'd9, 16'd1, 1'b0);
      beat(16'd3, 16'd3, 1'b1);
      drain();

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
